// File: rtl/rram_sched_pkg.sv
// ---------------------------------------------------------------------------
// rram_sched_pkg
// Shared definitions for the RRAM access scheduler:
//   - FSM state encoding (plain localparams so older tools and tests that
//     poke the raw state value keep working)
//   - controller operation encoding (RW: 1 = read, 0 = write)
//   - helper for locating a requester's field inside a packed request bus
// ---------------------------------------------------------------------------
package rram_sched_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE_W = 3'd1;
    localparam logic [2:0] ST_WAIT_W  = 3'd2;
    localparam logic [2:0] ST_ISSUE_R = 3'd3;
    localparam logic [2:0] ST_WAIT_R  = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    // Low bit index of requester 'port' inside a bus packed as
    // {port1_field, port0_field}, each 'width' bits wide.
    function automatic int field_lo(input logic port, input int width);
        return port ? width : 0;
    endfunction

endpackage

// File: rtl/rram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rram_rr_arbiter
// Two-way round-robin arbiter. When both requesters are valid the port after
// the last grantee wins; a single valid requester always wins. The last-grant
// pointer only moves when the grant is actually accepted, so a requester that
// is passed over keeps its turn.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low
//   req        in   [1:0] request valid per port
//   accept     in   grant taken this cycle (updates the pointer)
//   grant      out  [1:0] one-hot grant (zero when no request)
//   grant_idx  out  index of the granted port
// ---------------------------------------------------------------------------
module rram_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_grant;

    // Pick the winner: on contention favour the port that was not granted
    // last, otherwise whichever single port is asking.
    always_comb begin
        grant_idx = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req[1];
        end
        grant = 2'b00;
        if (req != 2'b00) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

    // Pointer starts at port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/rram_access_scheduler.sv
// ---------------------------------------------------------------------------
// rram_access_scheduler
// Two-port request scheduler in front of the RRAM controller. Arbitrates the
// host (port 0) and scrub/verify (port 1) requesters, pulses the one-cycle
// controller EN command, waits out the controller phase timing, and verifies
// every write with a read-back, re-writing up to MAX_RETRY extra times.
// Ports:
//   clk, reset             clock / synchronous active-low reset
//   REQ_VALID, REQ_READY   per-port request handshake (READY is a one-hot pulse)
//   REQ_RW/X/Y/WDATA       per-port request fields, packed {port1, port0}
//   RSP_VALID              one-cycle response pulse to the owning port
//   RSP_RDATA, RSP_ERR     read / last verify data, and verify-failed flag
//   EN, RW                 controller command pulse and operation
//   X_ADDRESS, Y_ADDRESS   controller word / select column address
//   WDATA                  column driver write data
//   SA_DOUT                sense-amplifier output
// ---------------------------------------------------------------------------
module rram_access_scheduler
    import rram_sched_pkg::*;
#(
    parameter int B_SIZE    = 4,
    parameter int X_SIZE    = 4,
    parameter int Y_SIZE    = 6,
    parameter int RD_WAIT   = 4,
    parameter int WR_WAIT   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            REQ_VALID,
    output logic [1:0]            REQ_READY,
    input  logic [1:0]            REQ_RW,
    input  logic [2*X_SIZE-1:0]   REQ_X,
    input  logic [2*Y_SIZE-1:0]   REQ_Y,
    input  logic [2*B_SIZE-1:0]   REQ_WDATA,
    output logic [1:0]            RSP_VALID,
    output logic [B_SIZE-1:0]     RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  EN,
    output logic                  RW,
    output logic [X_SIZE-1:0]     X_ADDRESS,
    output logic [Y_SIZE-1:0]     Y_ADDRESS,
    output logic [B_SIZE-1:0]     WDATA,
    input  logic [B_SIZE-1:0]     SA_DOUT
);

    // The wait counter is loaded with WAIT-1 and counts down to zero.
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [2:0]          state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [RETRY_W-1:0]  retry_cnt;
    logic                owner;
    logic                lat_op;
    logic [B_SIZE-1:0]   lat_wdata;

    logic [1:0]          grant;
    logic                grant_idx;
    logic                accept;

    logic                sel_rw;
    logic [X_SIZE-1:0]   sel_x;
    logic [Y_SIZE-1:0]   sel_y;
    logic [B_SIZE-1:0]   sel_wdata;

    rram_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (REQ_VALID),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Fields of the granted requester. Constant slice bases keep the mux
    // simple; the helper hides the packing order.
    always_comb begin
        sel_rw    = REQ_RW[grant_idx];
        sel_x     = grant_idx ? REQ_X[field_lo(1'b1, X_SIZE) +: X_SIZE]
                              : REQ_X[field_lo(1'b0, X_SIZE) +: X_SIZE];
        sel_y     = grant_idx ? REQ_Y[field_lo(1'b1, Y_SIZE) +: Y_SIZE]
                              : REQ_Y[field_lo(1'b0, Y_SIZE) +: Y_SIZE];
        sel_wdata = grant_idx ? REQ_WDATA[field_lo(1'b1, B_SIZE) +: B_SIZE]
                              : REQ_WDATA[field_lo(1'b0, B_SIZE) +: B_SIZE];
    end

    // Accept is gated with reset so no request is consumed while the block
    // is held in reset.
    always_comb begin
        accept    = reset && (state == ST_IDLE) && (REQ_VALID != 2'b00);
        REQ_READY = accept ? grant : 2'b00;
        EN        = (state == ST_ISSUE_W) || (state == ST_ISSUE_R);
        RSP_VALID = 2'b00;
        if (state == ST_RESP) begin
            RSP_VALID = owner ? 2'b10 : 2'b01;
        end
    end

    // Main sequencer. The X/Y/WDATA output registers double as the request
    // latch: they are loaded on accept and then held through every
    // write/verify retry. RW is changed only on the edge entering an ISSUE
    // state, so the controller never sees it move during a WAIT phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            owner     <= 1'b0;
            lat_op    <= OP_WRITE;
            lat_wdata <= '0;
            RW        <= 1'b0;
            X_ADDRESS <= '0;
            Y_ADDRESS <= '0;
            WDATA     <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner     <= grant_idx;
                        lat_op    <= sel_rw;
                        lat_wdata <= sel_wdata;
                        X_ADDRESS <= sel_x;
                        Y_ADDRESS <= sel_y;
                        WDATA     <= sel_wdata;
                        RW        <= sel_rw;
                        retry_cnt <= '0;
                        RSP_ERR   <= 1'b0;
                        state     <= (sel_rw == OP_READ) ? ST_ISSUE_R : ST_ISSUE_W;
                    end
                end
                ST_ISSUE_W: begin
                    wait_cnt <= CNT_W'(WR_WAIT - 1);
                    state    <= ST_WAIT_W;
                end
                ST_WAIT_W: begin
                    if (wait_cnt == '0) begin
                        RW    <= OP_READ;
                        state <= ST_ISSUE_R;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_ISSUE_R: begin
                    wait_cnt <= CNT_W'(RD_WAIT - 1);
                    state    <= ST_WAIT_R;
                end
                ST_WAIT_R: begin
                    if (wait_cnt == '0) begin
                        RSP_RDATA <= SA_DOUT;
                        if (lat_op == OP_READ || SA_DOUT == lat_wdata) begin
                            state <= ST_RESP;
                        end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            RW        <= OP_WRITE;
                            state     <= ST_ISSUE_W;
                        end else begin
                            RSP_ERR <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rram_access_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rram_access_scheduler
// Self-checking bench for rram_access_scheduler. A behavioural RRAM array
// model answers reads after RD_WAIT cycles (with garbage before and after the
// valid window) and can be told to return forced verify values. Expected
// latency, data, error flag and pulse counts come from transaction-level
// arithmetic on the request and the number of forced verify failures.
// ---------------------------------------------------------------------------
module tb_rram_access_scheduler;

    localparam int B   = 4;
    localparam int XS  = 4;
    localparam int YS  = 6;
    localparam int RDW = 4;
    localparam int WRW = 2;
    localparam int MR  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        REQ_VALID;
    logic [1:0]        REQ_READY;
    logic [1:0]        REQ_RW;
    logic [2*XS-1:0]   REQ_X;
    logic [2*YS-1:0]   REQ_Y;
    logic [2*B-1:0]    REQ_WDATA;
    logic [1:0]        RSP_VALID;
    logic [B-1:0]      RSP_RDATA;
    logic              RSP_ERR;
    logic              EN;
    logic              RW;
    logic [XS-1:0]     X_ADDRESS;
    logic [YS-1:0]     Y_ADDRESS;
    logic [B-1:0]      WDATA;
    logic [B-1:0]      SA_DOUT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Array contents seen by the device model, and the bench's own view of
    // what each location should hold.
    logic [B-1:0] mem     [16][64];
    logic [B-1:0] ref_mem [16][64];
    logic [B-1:0] forced_q[$];
    int           rd_timer = 0;
    logic [B-1:0] pending;

    int   en_wr, en_rd, first_en, addr_err;
    int   en_consec = 0;
    logic en_prev = 1'b0;
    logic chk_addr = 1'b0;
    logic [XS-1:0] exp_x;
    logic [YS-1:0] exp_y;
    logic [B-1:0]  exp_wdata;
    int   model_last = 1;

    rram_access_scheduler #(
        .B_SIZE(B), .X_SIZE(XS), .Y_SIZE(YS),
        .RD_WAIT(RDW), .WR_WAIT(WRW), .MAX_RETRY(MR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_RW    (REQ_RW),
        .REQ_X     (REQ_X),
        .REQ_Y     (REQ_Y),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .EN        (EN),
        .RW        (RW),
        .X_ADDRESS (X_ADDRESS),
        .Y_ADDRESS (Y_ADDRESS),
        .WDATA     (WDATA),
        .SA_DOUT   (SA_DOUT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Device model and bus monitor, evaluated mid-cycle. Reads return data
    // only in the cycle RD_WAIT after the EN pulse; any other cycle drives
    // random garbage so early or late capture is visible.
    always @(negedge clk) begin
        if (rd_timer > 0) begin
            rd_timer = rd_timer - 1;
            SA_DOUT  = (rd_timer == 0) ? pending : B'($urandom);
        end else begin
            SA_DOUT = B'($urandom);
        end
        if (EN) begin
            if (en_prev) en_consec++;
            if (first_en < 0) first_en = cyc;
            if (RW == 1'b0) begin
                en_wr++;
                mem[X_ADDRESS][Y_ADDRESS] = WDATA;
            end else begin
                en_rd++;
                if (forced_q.size() > 0) pending = forced_q.pop_front();
                else pending = mem[X_ADDRESS][Y_ADDRESS];
                rd_timer = RDW;
            end
        end
        if (chk_addr && first_en >= 0 &&
            (X_ADDRESS !== exp_x || Y_ADDRESS !== exp_y || WDATA !== exp_wdata))
            addr_err++;
        en_prev = EN;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic rw,
                                 input logic [XS-1:0] x, input logic [YS-1:0] y,
                                 input logic [B-1:0] wd);
        REQ_VALID[port]         = valid;
        REQ_RW[port]            = rw;
        REQ_X[port*XS +: XS]    = x;
        REQ_Y[port*YS +: YS]    = y;
        REQ_WDATA[port*B +: B]  = wd;
    endtask

    task automatic clearMonitor();
        en_wr = 0; en_rd = 0; first_en = -1; addr_err = 0;
    endtask

    // One request from one port, run to its response. nfail forced verify
    // mismatches (value fval) precede the array's real read-back.
    task automatic runTxn(input int port, input logic rw, input logic [XS-1:0] x,
                          input logic [YS-1:0] y, input logic [B-1:0] wd,
                          input int nfail, input logic [B-1:0] fval);
        int attempts, t, lat, exp_lat, exp_wr, exp_rd_cnt;
        logic [1:0] acc, rv;
        logic [B-1:0] rd, exp_rd;
        logic re, exp_err;
        forced_q.delete();
        if (!rw) for (int i = 0; i < nfail; i++) forced_q.push_back(fval);
        exp_x = x; exp_y = y; exp_wdata = wd; chk_addr = 1'b1;
        clearMonitor();
        applyStimulus(port, 1'b1, rw, x, y, wd);
        acc = 2'b00; t = 0;
        for (int i = 0; i < 10 && acc == 2'b00; i++) begin
            @(negedge clk); acc = REQ_READY; t = cyc;
        end
        checkOutput($sformatf("ready_p%0d", port), 32'(acc), 32'(2'b01 << port));
        @(posedge clk); #1;
        applyStimulus(port, 1'b0, rw, x, y, wd);
        rv = 2'b00; lat = 0; rd = '0; re = 1'b0;
        for (int i = 0; i < 60 && rv == 2'b00; i++) begin
            @(negedge clk); rv = RSP_VALID; lat = cyc - t; rd = RSP_RDATA; re = RSP_ERR;
        end
        #1;
        if (rw) begin
            exp_lat = 2 + RDW; exp_rd = ref_mem[x][y]; exp_err = 1'b0;
            exp_wr = 0; exp_rd_cnt = 1;
        end else begin
            attempts = ((nfail > MR) ? MR : nfail) + 1;
            exp_lat = 1 + attempts * (WRW + RDW + 2);
            exp_err = (nfail > MR);
            exp_rd  = exp_err ? fval : wd;
            exp_wr = attempts; exp_rd_cnt = attempts;
            ref_mem[x][y] = wd;
        end
        checkOutput("rsp_valid", 32'(rv), 32'(2'b01 << port));
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("rsp_rdata", 32'(rd), 32'(exp_rd));
        checkOutput("rsp_err", 32'(re), 32'(exp_err));
        checkOutput("en_write_pulses", 32'(en_wr), 32'(exp_wr));
        checkOutput("en_read_pulses", 32'(en_rd), 32'(exp_rd_cnt));
        checkOutput("first_en_offset", 32'(first_en - t), 32'd1);
        checkOutput("addr_data_stable", 32'(addr_err), 32'd0);
        model_last = port;
        chk_addr = 1'b0;
        @(posedge clk); #1;
    endtask

    // Both ports hold reads; grants must alternate and every response must
    // come back to the right port with the right data.
    task automatic runArbitration();
        logic [XS-1:0] xa [2];
        logic [YS-1:0] ya [2];
        int exp_next, gport, gcyc, nrsp;
        clearMonitor(); forced_q.delete(); chk_addr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            xa[p] = XS'($urandom); ya[p] = YS'($urandom);
            applyStimulus(p, 1'b1, 1'b1, xa[p], ya[p], B'($urandom));
        end
        exp_next = 1 - model_last; gport = 0; gcyc = 0; nrsp = 0;
        for (int i = 0; i < 80 && nrsp < 4; i++) begin
            @(negedge clk);
            if (REQ_READY != 2'b00) begin
                checkOutput("arb_grant", 32'(REQ_READY), 32'(2'b01 << exp_next));
                gport = exp_next; gcyc = cyc; model_last = exp_next; exp_next = 1 - exp_next;
            end
            if (RSP_VALID != 2'b00) begin
                checkOutput("arb_rsp_port", 32'(RSP_VALID), 32'(2'b01 << gport));
                checkOutput("arb_latency", 32'(cyc - gcyc), 32'(2 + RDW));
                checkOutput("arb_rdata", 32'(RSP_RDATA), 32'(ref_mem[xa[gport]][ya[gport]]));
                nrsp++;
            end
        end
        checkOutput("arb_rsp_count", 32'(nrsp), 32'd4);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b1, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b1, '0, '0, '0);
        #1;
        checkOutput("arb_en_reads", 32'(en_rd), 32'd4);
        checkOutput("en_never_consecutive", 32'(en_consec), 32'd0);
    endtask

    // Start a write, pull reset during the write-wait phase and confirm the
    // request is dropped with no further controller activity or response.
    task automatic runResetAbort();
        logic [XS-1:0] x;
        logic [YS-1:0] y;
        logic [B-1:0]  wd;
        logic [1:0]    acc;
        int            rsp_seen;
        x = XS'($urandom); y = YS'($urandom); wd = B'($urandom);
        forced_q.delete(); chk_addr = 1'b0; clearMonitor();
        applyStimulus(0, 1'b1, 1'b0, x, y, wd);
        acc = 2'b00;
        for (int i = 0; i < 10 && acc == 2'b00; i++) begin
            @(negedge clk); acc = REQ_READY;
        end
        checkOutput("abort_ready", 32'(acc), 32'(2'b01));
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, x, y, wd);
        for (int i = 0; i < 5 && en_wr == 0; i++) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_en_low", 32'(EN), 32'd0);
        checkOutput("abort_no_rsp", 32'(RSP_VALID), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (RSP_VALID != 2'b00) rsp_seen++;
        end
        checkOutput("abort_dropped", 32'(rsp_seen), 32'd0);
        checkOutput("abort_en_total", 32'(en_wr + en_rd), 32'd1);
        ref_mem[x][y] = wd;
        model_last = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        int port, nfail;
        logic rw;
        logic [B-1:0] wd, fval;

        reset = 1'b0;
        REQ_VALID = 2'b11; REQ_RW = '0; REQ_X = '0; REQ_Y = '0; REQ_WDATA = '0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 64; j++) begin
                mem[i][j] = B'($urandom); ref_mem[i][j] = mem[i][j];
            end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(REQ_READY), 32'd0);
        checkOutput("reset_en", 32'(EN), 32'd0);
        checkOutput("reset_rw", 32'(RW), 32'd0);
        checkOutput("reset_x", 32'(X_ADDRESS), 32'd0);
        checkOutput("reset_y", 32'(Y_ADDRESS), 32'd0);
        checkOutput("reset_wdata", 32'(WDATA), 32'd0);
        checkOutput("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        checkOutput("reset_rsp_rdata", 32'(RSP_RDATA), 32'd0);
        checkOutput("reset_rsp_err", 32'(RSP_ERR), 32'd0);
        REQ_VALID = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset released");

        runArbitration();

        mem[2][4] = 4'hA; ref_mem[2][4] = 4'hA;
        runTxn(0, 1'b1, 4'd2, 6'd4, 4'h6, 0, 4'h0);
        runTxn(1, 1'b0, 4'd15, 6'd63, 4'h5, 0, 4'h0);
        runTxn(0, 1'b0, 4'd7, 6'd9, 4'h3, 2, 4'h0);
        runTxn(1, 1'b0, 4'd3, 6'd33, 4'h1, 4, 4'hF);
        runTxn(1, 1'b1, 4'd3, 6'd33, 4'h0, 0, 4'h0);
        $display("[TB] directed cases done");

        runResetAbort();
        runTxn(0, 1'b1, 4'd9, 6'd17, 4'h0, 0, 4'h0);
        $display("[TB] reset abort done");

        for (int n = 0; n < 16; n++) begin
            port  = int'($urandom_range(0, 1));
            rw    = 1'($urandom_range(0, 1));
            wd    = B'($urandom);
            nfail = rw ? 0 : int'($urandom_range(0, MR + 1));
            fval  = wd ^ B'($urandom_range(1, 15));
            runTxn(port, rw, XS'($urandom), YS'($urandom), wd, nfail, fval);
        end

        checkOutput("final_en_consec", 32'(en_consec), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rram_access_scheduler.md
# rram_access_scheduler

Two-port request scheduler in front of `controller_5V`. It round-robin arbitrates two requesters (host port 0, scrub/verify port 1), pulses the controller's one-cycle `EN` command, and waits out the controller phase timing. Every write gets a verify read-back against the sense-amp output, with bounded re-write retries. It owns all `EN`/`RW`/address/data drive into the RRAM controller.

## Interface
Parameters:
- `B_SIZE`, 4, word width in bits
- `X_SIZE`, 4, word-column address bits
- `Y_SIZE`, 6, select-column address bits
- `RD_WAIT`, 4, cycles after a read `EN` pulse until `SA_DOUT` is valid (RPH1..RPH3 plus sense)
- `WR_WAIT`, 2, cycles after a write `EN` pulse until the array is free (WPH1 plus recovery)
- `MAX_RETRY`, 3, extra write attempts after a failed verify (0 = none)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low
- `REQ_VALID` in 2: request valid, one bit per requester
- `REQ_READY` out 2: one-hot accept pulse
- `REQ_RW` in 2: per requester, 1 = read, 0 = write (controller encoding)
- `REQ_X` in 2*X_SIZE: packed, requester i at `[i*X_SIZE +: X_SIZE]`
- `REQ_Y` in 2*Y_SIZE: packed, same scheme
- `REQ_WDATA` in 2*B_SIZE: packed, same scheme
- `RSP_VALID` out 2: one-cycle response pulse to the owning requester
- `RSP_RDATA` out B_SIZE: read data, or last verify data for writes
- `RSP_ERR` out 1: write verify failed after all retries; qualified by `RSP_VALID`
- `EN` out 1: controller command pulse
- `RW` out 1: controller op
- `X_ADDRESS` out X_SIZE: controller word-column address
- `Y_ADDRESS` out Y_SIZE: controller select-column address
- `WDATA` out B_SIZE: write data to the column drivers
- `SA_DOUT` in B_SIZE: sense-amplifier output

## Operation
- States: `IDLE`, `ISSUE_W`, `WAIT_W`, `ISSUE_R`, `WAIT_R`, `RESP`.
- `IDLE`:
  - If any `REQ_VALID` is high, grant one requester by round-robin, starting from the port after the last grantee.
  - After reset, port 0 has priority.
  - Assert `REQ_READY[g]` for that one cycle and latch op, X, Y and WDATA.
  - Go to `ISSUE_R` for a read, `ISSUE_W` for a write.
- `ISSUE_W`: `EN`=1, `RW`=0, then `WAIT_W` for `WR_WAIT` cycles, then `ISSUE_R` (verify).
- `ISSUE_R`: `EN`=1, `RW`=1, then `WAIT_R` for `RD_WAIT` cycles.
- Last `WAIT_R` cycle:
  - Capture `SA_DOUT` into `RSP_RDATA`.
  - Read op: go to `RESP`.
  - Write op: compare capture with latched WDATA.
  - Match: go to `RESP` with `RSP_ERR`=0.
  - Mismatch and retry count < `MAX_RETRY`: increment the count and go to `ISSUE_W`.
  - Mismatch otherwise: go to `RESP` with `RSP_ERR`=1.
- `RESP`: `RSP_VALID[g]`=1 for exactly one cycle, then `IDLE`. There is no response backpressure.
- Reads never retry. The retry counter is `$clog2(MAX_RETRY+1)` bits (minimum 1) and clears on every grant.

## Timing
- Reset values: all outputs 0; state `IDLE`; RR pointer favours port 0; retry count 0.
- Reset asserted mid-operation:
  - State returns to `IDLE` on that edge.
  - `EN` is low from that edge.
  - The in-flight request is dropped silently (no `RSP_VALID`).
- `X_ADDRESS`, `Y_ADDRESS`, `RW` and `WDATA` are updated from the latches at `ISSUE_*`. They stay stable until the next `ISSUE_*`, with no changes during `WAIT_*`.
- Accept at cycle T gives:
  - Read: `EN` at T+1, `RSP_VALID` at T+2+`RD_WAIT` (T+6 default).
  - Write, passing first verify: write `EN` T+1, verify `EN` T+2+`WR_WAIT`, `RSP_VALID` T+3+`WR_WAIT`+`RD_WAIT` (T+9 default).
  - Each retry adds `WR_WAIT`+`RD_WAIT`+2 cycles (8 default).
- `EN` is never high on two consecutive cycles.
- `REQ_READY` is only high in `IDLE`. Back-to-back requests have a minimum of one idle cycle (the `RESP`→`IDLE` boundary).
- Both `REQ_VALID` high: the grant alternates; the loser holds valid, and nothing is dropped.
- A requester may drop `REQ_VALID` before grant without effect.

## Structure
- Package `rram_sched_pkg`: state encoding, the `OP_READ`=1/`OP_WRITE`=0 constants, and the packed-field index helpers.
- Sub-module `rram_rr_arbiter`: 2-way round-robin arbiter with one-hot grant and a last-grant pointer, updated only on accept.
- The FSM, wait counter, retry counter and compare live in `rram_access_scheduler`.

## Test plan
- Reset, then port 0 reads X=2, Y=4 with `SA_DOUT`=4'hA → `EN` pulses once at T+1 with `RW`=1, X=2, Y=4; `RSP_VALID`=2'b01 at T+6; `RSP_RDATA`=4'hA.
- Port 1 writes X=15, Y=63, WDATA=4'h5; model returns 4'h5 on verify → two `EN` pulses (T+1 `RW`=0, T+4 `RW`=1); `RSP_VALID`=2'b10 at T+9; `RSP_ERR`=0.
- Write with WDATA=4'h3; model returns 4'h0 twice, then 4'h3 → three write pulses; response at T+25; `RSP_ERR`=0.
- Write whose verify always returns 4'hF ≠ 4'h1 → 4 write/verify pairs; response at T+33; `RSP_ERR`=1; next request accepted normally.
- Both ports hold reads continuously → grants alternate 0,1,0,1; no response lost; `EN` never high on consecutive cycles.
- `reset` driven low during `WAIT_W` → `EN`=0 and `IDLE` next cycle, no `RSP_VALID`; a new request after release completes with nominal latency.
